// File: rtl/clk_reset_seq_pkg.sv
// Shared state encoding and sizing helpers for the clock/reset sequencer.
// The state codes are also decoded by the LED/debug block.
package clk_reset_seq_pkg;

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      S_WAIT   = 2'd0,
      S_STABLE = 2'd1,
      S_VID    = 2'd2,
      S_RUN    = 2'd3
   } state_t;

   // Bits needed to count 0..max(a,b)-1, never less than one.
   function automatic int unsigned width_of_max(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/clk_reset_seq_sync2.sv
// Two-flop synchronizer for a single asynchronous level, cleared by synchronous reset.
module clk_reset_seq_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/clk_reset_seq.sv
// Power-up sequencer for the pixel-clock domain: qualifies PLL lock, releases video
// then CPU reset, generates the CPU clock-enable, and handles the CPU reset button.
module clk_reset_seq
   import clk_reset_seq_pkg::*;
#(
   parameter int unsigned LOCK_CYCLES = 1024,
   parameter int unsigned CPU_DELAY   = 256,
   parameter int unsigned CE_DIV      = 8,
   parameter int unsigned DEBOUNCE    = 65536
) (
   input  logic               clkin,
   input  logic               rst,
   input  logic               locked,
   input  logic               key_rst,
   output logic               rst_vid,
   output logic               rst_cpu,
   output logic               ce_cpu,
   output logic               ready,
   output logic [STATE_W-1:0] state
);

   localparam int unsigned CNT_W = width_of_max(LOCK_CYCLES, CPU_DELAY);
   localparam int unsigned DIV_W = width_of_max(CE_DIV, 2);
   localparam int unsigned DEB_W = width_of_max(DEBOUNCE, 2);

   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [CNT_W-1:0] CPU_LAST  = CNT_W'(CPU_DELAY - 1);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CE_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE - 1);

   logic             w_lock_s;
   logic             w_key_s;
   logic [DEB_W-1:0] r_deb;
   logic             r_key_ok;
   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] w_div_nxt;
   logic             w_ce_nxt;
   logic             r_rst_vid;
   logic             r_rst_cpu;
   logic             r_ce_cpu;
   logic             r_ready;

   clk_reset_seq_sync2 u_sync_lock (
      .clk (clkin),
      .rst (rst),
      .i_d (locked),
      .o_q (w_lock_s)
   );

   clk_reset_seq_sync2 u_sync_key (
      .clk (clkin),
      .rst (rst),
      .i_d (key_rst),
      .o_q (w_key_s)
   );

   // key_ok needs the counter saturated and one more synced-high sample.
   always_ff @(posedge clkin) begin
      if (rst || !w_key_s) begin
         r_deb    <= '0;
         r_key_ok <= 1'b0;
      end else begin
         if (r_deb != DEB_LAST) begin
            r_deb <= r_deb + DEB_W'(1);
         end
         r_key_ok <= (r_deb == DEB_LAST);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (!w_lock_s) begin
         w_state_nxt = S_WAIT;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            S_WAIT: begin
               w_state_nxt = S_STABLE;
               w_cnt_nxt   = '0;
            end
            S_STABLE: begin
               if (r_cnt == LOCK_LAST) begin
                  w_state_nxt = S_VID;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            S_VID: begin
               if (r_key_ok) begin
                  w_cnt_nxt = '0;
               end else if (r_cnt == CPU_LAST) begin
                  w_state_nxt = S_RUN;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            S_RUN: begin
               if (r_key_ok) begin
                  w_state_nxt = S_VID;
                  w_cnt_nxt   = '0;
               end
            end
            default: begin
               w_state_nxt = S_WAIT;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Divider only runs while staying in S_RUN, so entry restarts the CE phase.
   always_comb begin
      w_div_nxt = '0;
      w_ce_nxt  = 1'b0;
      if ((r_state == S_RUN) && (w_state_nxt == S_RUN)) begin
         if (r_div == DIV_LAST) begin
            w_ce_nxt = 1'b1;
         end else begin
            w_div_nxt = r_div + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clkin) begin
      if (rst) begin
         r_state   <= S_WAIT;
         r_cnt     <= '0;
         r_div     <= '0;
         r_rst_vid <= 1'b1;
         r_rst_cpu <= 1'b1;
         r_ce_cpu  <= 1'b0;
         r_ready   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_div     <= w_div_nxt;
         r_rst_vid <= (w_state_nxt == S_WAIT) || (w_state_nxt == S_STABLE);
         r_rst_cpu <= (w_state_nxt != S_RUN);
         r_ce_cpu  <= w_ce_nxt;
         r_ready   <= (w_state_nxt == S_RUN);
      end
   end

   assign rst_vid = r_rst_vid;
   assign rst_cpu = r_rst_cpu;
   assign ce_cpu  = r_ce_cpu;
   assign ready   = r_ready;
   assign state   = r_state;

endmodule

// File: tb/tb_clk_reset_seq.sv
// Directed bench for clk_reset_seq with short qualification/delay/debounce settings.
module tb_clk_reset_seq;

   logic       clkin   = 1'b0;
   logic       rst     = 1'b1;
   logic       locked  = 1'b0;
   logic       key_rst = 1'b0;
   logic       rst_vid;
   logic       rst_cpu;
   logic       ce_cpu;
   logic       ready;
   logic [1:0] state;

   int errors = 0;
   int checks = 0;

   always #5 clkin = ~clkin;

   clk_reset_seq #(
      .LOCK_CYCLES (16),
      .CPU_DELAY   (8),
      .CE_DIV      (4),
      .DEBOUNCE    (4)
   ) dut (
      .clkin   (clkin),
      .rst     (rst),
      .locked  (locked),
      .key_rst (key_rst),
      .rst_vid (rst_vid),
      .rst_cpu (rst_cpu),
      .ce_cpu  (ce_cpu),
      .ready   (ready),
      .state   (state)
   );

   task automatic step();
      @(posedge clkin);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Compares state plus the reset/ready levels that state implies.
   task automatic check_st(input string tag, input int e, input logic [1:0] st);
      check($sformatf("%s e%0d state", tag, e), 8'(state), 8'(st));
      check($sformatf("%s e%0d rst_vid", tag, e), 8'(rst_vid), 8'(st < 2'd2));
      check($sformatf("%s e%0d rst_cpu", tag, e), 8'(rst_cpu), 8'(st != 2'd3));
      check($sformatf("%s e%0d ready", tag, e), 8'(ready), 8'(st == 2'd3));
   endtask

   initial begin
      logic [1:0] st;

      // 1: reset with no lock, then idle
      rst = 1'b1;
      locked = 1'b0;
      repeat (3) step();
      check_st("reset", 0, 2'd0);
      check("reset ce", 8'(ce_cpu), 8'd0);
      rst = 1'b0;
      repeat (5) step();
      check_st("idle", 0, 2'd0);
      check("idle ce", 8'(ce_cpu), 8'd0);

      // 2: clean power-up, locked rises before E0
      locked = 1'b1;
      for (int e = 0; e <= 40; e++) begin
         step();
         st = (e < 2) ? 2'd0 : (e < 18) ? 2'd1 : (e < 26) ? 2'd2 : 2'd3;
         check_st("powerup", e, st);
         check($sformatf("powerup e%0d ce", e), 8'(ce_cpu),
               8'((e >= 30) && (((e - 30) % 4) == 0)));
      end

      // 3: one-cycle lock glitch captured at E10
      rst = 1'b1;
      locked = 1'b0;
      step();
      step();
      rst = 1'b0;
      locked = 1'b1;
      for (int e = 0; e <= 40; e++) begin
         step();
         if (e == 9)  locked = 1'b0;
         if (e == 10) locked = 1'b1;
         st = (e < 2) ? 2'd0 : (e < 12) ? 2'd1 : (e == 12) ? 2'd0 :
              (e < 29) ? 2'd1 : (e < 37) ? 2'd2 : 2'd3;
         check_st("glitch", e, st);
         check($sformatf("glitch e%0d ce", e), 8'(ce_cpu), 8'd0);
      end

      // 4a: short button press is filtered
      key_rst = 1'b1;
      for (int k = 0; k <= 11; k++) begin
         step();
         if (k == 2) key_rst = 1'b0;
         check_st("keyshort", k, 2'd3);
      end

      // 4b: long press resets only the CPU, CE restarts on re-entry
      key_rst = 1'b1;
      for (int k = 0; k <= 25; k++) begin
         step();
         if (k == 9) key_rst = 1'b0;
         st = (k < 6) ? 2'd3 : (k < 20) ? 2'd2 : 2'd3;
         check_st("keylong", k, st);
         if (k >= 6) check($sformatf("keylong k%0d ce", k), 8'(ce_cpu), 8'(k == 24));
      end

      // 5: lock loss while running
      locked = 1'b0;
      for (int l = 0; l <= 6; l++) begin
         step();
         check_st("lockloss", l, (l < 2) ? 2'd3 : 2'd0);
         if (l >= 2) check($sformatf("lockloss l%0d ce", l), 8'(ce_cpu), 8'd0);
      end

      // 6: rst pulse while in S_VID
      locked = 1'b1;
      for (int m = 0; m <= 20; m++) begin
         step();
      end
      check_st("pre_rst", 20, 2'd2);
      rst = 1'b1;
      step();
      check_st("midrst", 0, 2'd0);
      check("midrst ce", 8'(ce_cpu), 8'd0);
      rst = 1'b0;
      for (int r = 0; r <= 2; r++) begin
         step();
         check_st("restart", r, (r < 2) ? 2'd0 : 2'd1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
